calc_seq_ctrl: RTL

//  Sequencing controller for the 2-digit BCD adder calculator.
//  - Cleans the raw push-button inputs: synchronises, debounces and edge-detects them.
//  - Steps the IDLE -> ENTRY -> CALC -> RESULT flow.
//  - Owns the operand digit registers and the adder, and drives the six 7-seg digit codes.
//  - Sits between board buttons and the seven-segment decoders; single clock domain.

---
 rtl/calc_seq_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: sequencing controller for a 2-digit BCD adder calculator.
// Conditions five raw push-buttons (sync, debounce, rising-edge detect), steps
// the IDLE -> ENTRY -> CALC -> RESULT flow, holds the BCD operand digits and
// drives six registered 7-seg digit codes.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cal, key3..key0    raw buttons (async to clk, active-high)
//   dig6..dig1         digit codes 0-9 or BLANK (registered)
//   state              current FSM state (0 IDLE, 1 ENTRY, 2 CALC, 3 RESULT)
//   result             binary sum, non-zero only in RESULT
module calc_seq_ctrl #(
    parameter int unsigned DB_CYCLES = 4,
    parameter logic [3:0]  BLANK     = 4'hA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cal,
    input  logic       key3,
    input  logic       key2,
    input  logic       key1,
    input  logic       key0,
    output logic [3:0] dig6,
    output logic [3:0] dig5,
    output logic [3:0] dig4,
    output logic [3:0] dig3,
    output logic [3:0] dig2,
    output logic [3:0] dig1,
    output logic [1:0] state,
    output logic [7:0] result
);

    localparam int unsigned NCH = 5;
    localparam int unsigned CW  = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTRY  = 2'd1,
        S_CALC   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    // Channel order: {cal, key3, key2, key1, key0}
    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] level;
    logic [NCH-1:0] level_d;
    logic [NCH-1:0] ev;
    logic [CW-1:0]  db_cnt [NCH];

    assign raw = {cal, key3, key2, key1, key0};

    // Synchroniser, debounce counters and registered rising-edge events
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            ev      <= '0;
            for (int i = 0; i < NCH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            ev      <= level & ~level_d;
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                    // This increment would reach DB_CYCLES: flip the level instead
                    level[i]  <= ~level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    logic cal_ev;
    logic k3_ev;
    logic k2_ev;
    logic k1_ev;
    logic k0_ev;

    assign {cal_ev, k3_ev, k2_ev, k1_ev, k0_ev} = ev;

    state_t     state_q;
    state_t     state_nxt;
    logic [3:0] a_t;
    logic [3:0] a_o;
    logic [3:0] b_t;
    logic [3:0] b_o;
    logic [3:0] a_t_nxt;
    logic [3:0] a_o_nxt;
    logic [3:0] b_t_nxt;
    logic [3:0] b_o_nxt;
    logic [3:0] dig6_nxt;
    logic [3:0] dig5_nxt;
    logic [3:0] dig4_nxt;
    logic [3:0] dig3_nxt;
    logic [3:0] dig2_nxt;
    logic [3:0] dig1_nxt;
    logic [7:0] result_nxt;

    // BCD digit increment with 9 -> 0 wrap and no carry out
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // BCD addition of the operands for the result display, plus binary sum
    logic [4:0] o_sum;
    logic [4:0] t_sum;
    logic       c_ones;
    logic       c_tens;
    logic [3:0] o_dig;
    logic [3:0] t_dig;
    logic [7:0] bin_sum;

    assign o_sum   = {1'b0, a_o} + {1'b0, b_o};
    assign c_ones  = (o_sum > 5'd9);
    assign o_dig   = c_ones ? 4'(o_sum - 5'd10) : o_sum[3:0];
    assign t_sum   = {1'b0, a_t} + {1'b0, b_t} + {4'b0000, c_ones};
    assign c_tens  = (t_sum > 5'd9);
    assign t_dig   = c_tens ? 4'(t_sum - 5'd10) : t_sum[3:0];
    assign bin_sum = 8'(a_t) * 8'd10 + 8'(a_o) + 8'(b_t) * 8'd10 + 8'(b_o);

    // State, operand and display registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_t     <= '0;
            a_o     <= '0;
            b_t     <= '0;
            b_o     <= '0;
            dig6    <= BLANK;
            dig5    <= BLANK;
            dig4    <= BLANK;
            dig3    <= BLANK;
            dig2    <= BLANK;
            dig1    <= BLANK;
            result  <= '0;
        end else begin
            state_q <= state_nxt;
            a_t     <= a_t_nxt;
            a_o     <= a_o_nxt;
            b_t     <= b_t_nxt;
            b_o     <= b_o_nxt;
            dig6    <= dig6_nxt;
            dig5    <= dig5_nxt;
            dig4    <= dig4_nxt;
            dig3    <= dig3_nxt;
            dig2    <= dig2_nxt;
            dig1    <= dig1_nxt;
            result  <= result_nxt;
        end
    end

    // Next-state, operand and display logic
    always_comb begin
        state_nxt  = state_q;
        a_t_nxt    = a_t;
        a_o_nxt    = a_o;
        b_t_nxt    = b_t;
        b_o_nxt    = b_o;
        dig6_nxt   = dig6;
        dig5_nxt   = dig5;
        dig4_nxt   = dig4;
        dig3_nxt   = dig3;
        dig2_nxt   = dig2;
        dig1_nxt   = dig1;
        result_nxt = result;

        case (state_q)
            S_IDLE: begin
                if (cal_ev) begin
                    state_nxt = S_ENTRY;
                    a_t_nxt   = '0;
                    a_o_nxt   = '0;
                    b_t_nxt   = '0;
                    b_o_nxt   = '0;
                    dig6_nxt  = 4'd0;
                    dig5_nxt  = 4'd0;
                    dig4_nxt  = BLANK;
                    dig3_nxt  = BLANK;
                    dig2_nxt  = 4'd0;
                    dig1_nxt  = 4'd0;
                end
            end
            S_ENTRY: begin
                if (cal_ev) begin
                    // cal wins; key events in the same cycle are dropped
                    state_nxt = S_CALC;
                end else begin
                    if (k3_ev) a_t_nxt = bcd_inc(a_t);
                    if (k2_ev) a_o_nxt = bcd_inc(a_o);
                    if (k1_ev) b_t_nxt = bcd_inc(b_t);
                    if (k0_ev) b_o_nxt = bcd_inc(b_o);
                    dig6_nxt = a_t_nxt;
                    dig5_nxt = a_o_nxt;
                    dig2_nxt = b_t_nxt;
                    dig1_nxt = b_o_nxt;
                end
            end
            S_CALC: begin
                state_nxt  = S_RESULT;
                result_nxt = bin_sum;
                dig6_nxt   = BLANK;
                dig5_nxt   = BLANK;
                dig4_nxt   = BLANK;
                dig3_nxt   = c_tens ? 4'd1 : BLANK;
                // Suppress the leading zero when the sum is a single digit
                dig2_nxt   = (!c_tens && t_dig == 4'd0) ? BLANK : t_dig;
                dig1_nxt   = o_dig;
            end
            S_RESULT: begin
                if (cal_ev) begin
                    state_nxt  = S_IDLE;
                    result_nxt = '0;
                    dig6_nxt   = BLANK;
                    dig5_nxt   = BLANK;
                    dig4_nxt   = BLANK;
                    dig3_nxt   = BLANK;
                    dig2_nxt   = BLANK;
                    dig1_nxt   = BLANK;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule
